// File: rtl/core_pkg.sv
// Shared AXI constants and loader state encoding.
package core_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } iccm_loader_state_t;

endpackage

// File: rtl/iccm_loader_if.sv
// AXI4 write-channel bundle between the loader (master) and the ICCM (slave).
interface iccm_loader_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [1:0]        s_axi_awburst;
  logic [ID_W-1:0]   s_axi_awid;
  logic [7:0]        s_axi_awlen;
  logic [2:0]        s_axi_awsize;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awburst, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awburst, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready
  );
endinterface

// File: rtl/iccm_burst_calc.sv
// Burst length: min(remaining words, MAX_BURST, words left in the current 4 KB page).
module iccm_burst_calc #(
  parameter int MAX_BURST = 16
) (
  input  logic [9:0]  word_off_i,
  input  logic [15:0] remaining_i,
  output logic [8:0]  beats_o
);
  localparam logic [16:0] MAX_L = 17'(MAX_BURST);

  logic [16:0] room;
  logic [16:0] m;

  // Clamp the remaining count by the burst cap and the distance to the page end.
  always_comb begin
    room = 17'd1024 - {7'd0, word_off_i};
    m    = {1'b0, remaining_i};
    if (m > MAX_L) m = MAX_L;
    if (m > room)  m = room;
    beats_o = m[8:0];
  end
endmodule

// File: rtl/iccm_loader.sv
// Boot-time ICCM image loader: packs a word stream into 4 KB-safe AXI INCR
// bursts, checks every write response and holds the core until success.
module iccm_loader
  import core_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_BURST = 16,
  parameter int AXI_ID    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       word_count,
  input  logic [31:0]       src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              core_hold,
  iccm_loader_if.master     axi
);
  localparam logic [ID_W-1:0] AWID = ID_W'(AXI_ID);

  iccm_loader_state_t state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        rem_q, rem_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;
  logic [8:0]         beats;
  logic [8:0]         len_m1;
  logic               unused_bits;

  assign unused_bits = ^{axi.s_axi_bid, base_addr[1:0]};

  iccm_burst_calc #(.MAX_BURST(MAX_BURST)) u_calc (
    .word_off_i  (addr_q[11:2]),
    .remaining_i (rem_q),
    .beats_o     (beats)
  );

  assign len_m1    = beats - 9'd1;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign error     = error_q;
  assign core_hold = hold_q;

  // State and bookkeeping registers; reset abandons any load in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and AXI channel drive; addr advances one word per accepted beat,
  // which leaves it at addr + 4*beats once the burst completes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    error_d = error_q;
    hold_d  = hold_q;

    axi.s_axi_awaddr  = addr_q;
    axi.s_axi_awburst = AXI_BURST_INCR;
    axi.s_axi_awid    = AWID;
    axi.s_axi_awlen   = 8'd0;
    axi.s_axi_awsize  = AXI_SIZE_4B;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata   = src_data;
    axi.s_axi_wstrb   = 4'hF;
    axi.s_axi_wlast   = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    axi.s_axi_bready  = 1'b0;
    src_ready         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (word_count != 16'd0) begin
            addr_d  = {base_addr[ADDR_W-1:2], 2'b00};
            rem_d   = word_count;
            state_d = ST_AW;
          end else begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end
        end
      end
      ST_AW: begin
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_awlen   = len_m1[7:0];
        if (axi.s_axi_awready) begin
          cnt_d   = beats;
          state_d = ST_W;
        end
      end
      ST_W: begin
        axi.s_axi_wvalid = src_valid;
        axi.s_axi_wlast  = (cnt_q == 9'd1);
        src_ready        = axi.s_axi_wready;
        if (src_valid && axi.s_axi_wready) begin
          cnt_d  = cnt_q - 9'd1;
          rem_d  = rem_q - 16'd1;
          addr_d = addr_q + ADDR_W'(4);
          if (cnt_q == 9'd1) state_d = ST_B;
        end
      end
      ST_B: begin
        axi.s_axi_bready = 1'b1;
        if (axi.s_axi_bvalid) begin
          if (axi.s_axi_bresp != AXI_RESP_OKAY) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (rem_q != 16'd0) begin
            state_d = ST_AW;
          end else begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_iccm_loader.sv
// Randomized scoreboard bench for iccm_loader with an AXI slave memory model.
module tb_iccm_loader;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int MAX_BURST = 16;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [31:0] data; logic last; } w_t;
  typedef struct packed { logic err; logic hold; } d_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic [31:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_ready, busy, done, error, core_hold;

  iccm_loader_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

  iccm_loader #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BURST(MAX_BURST), .AXI_ID(0)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready), .busy(busy),
    .done(done), .error(error), .core_hold(core_hold), .axi(axi.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  aw_t         exp_aw[$];
  w_t          exp_w[$];
  d_t          exp_done[$];
  logic [31:0] src_q[$];
  logic [31:0] mem[int];
  int          cur_keys[$];
  logic [31:0] cur_vals[$];
  bit          cur_ok;
  int          cur_left;
  bit          hold_m = 1'b1;
  bit          stall = 1'b0;
  int          err_burst = -1;
  int          b_idx = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // AXI slave memory and word source, driven just after each rising edge.
  initial begin
    logic [31:0] slv_addr;
    bit pend_b, b_hs, s_hs;
    slv_addr = '0; pend_b = 0;
    axi.s_axi_awready = 0; axi.s_axi_wready = 0; axi.s_axi_bvalid = 0;
    axi.s_axi_bresp = 0; axi.s_axi_bid = '0;
    forever begin
      @(negedge clk);
      b_hs = 0; s_hs = 0;
      if (reset) begin
        pend_b = 0;
        axi.s_axi_awready = 0; axi.s_axi_wready = 0; axi.s_axi_bvalid = 0;
        src_valid = 0;
      end else begin
        if (axi.s_axi_awvalid && axi.s_axi_awready) slv_addr = axi.s_axi_awaddr;
        if (axi.s_axi_wvalid && axi.s_axi_wready) begin
          mem[int'(slv_addr >> 2)] = axi.s_axi_wdata;
          slv_addr += 32'd4;
          if (axi.s_axi_wlast) pend_b = 1;
        end
        if (axi.s_axi_bvalid && axi.s_axi_bready) begin
          b_hs = 1; pend_b = 0; b_idx++;
        end
        if (src_valid && src_ready) begin
          s_hs = 1;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
      end
      @(posedge clk); #1;
      if (!reset) begin
        axi.s_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.s_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (b_hs) axi.s_axi_bvalid = 0;
        else if (pend_b && !axi.s_axi_bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
          axi.s_axi_bvalid = 1;
          axi.s_axi_bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        end
        src_valid = (src_q.size() > 0) &&
                    ((src_valid && !s_hs) || !stall || $urandom_range(0, 1) == 1);
        src_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake or done.
  initial begin
    aw_t a; w_t w; d_t d;
    bit pv;
    logic [31:0] pa;
    pv = 0; pa = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0;
      end else begin
        if (pv) begin
          chk("awvalid_hold", axi.s_axi_awvalid, 1);
          chk("awaddr_hold", axi.s_axi_awaddr, pa);
        end
        if (axi.s_axi_awvalid && axi.s_axi_awready) begin
          chk("aw_expected", exp_aw.size() > 0, 1);
          if (exp_aw.size() > 0) begin
            a = exp_aw.pop_front();
            chk("awaddr", axi.s_axi_awaddr, a.addr);
            chk("awlen", axi.s_axi_awlen, a.len);
            chk("awburst", axi.s_axi_awburst, 2'b01);
            chk("awsize", axi.s_axi_awsize, 3'b010);
          end
        end
        if (axi.s_axi_wvalid && axi.s_axi_wready) begin
          chk("w_expected", exp_w.size() > 0, 1);
          if (exp_w.size() > 0) begin
            w = exp_w.pop_front();
            chk("wdata", axi.s_axi_wdata, w.data);
            chk("wlast", axi.s_axi_wlast, w.last);
            chk("wstrb", axi.s_axi_wstrb, 4'hF);
          end
        end
        if (done) begin
          chk("done_expected", exp_done.size() > 0, 1);
          if (exp_done.size() > 0) begin
            d = exp_done.pop_front();
            chk("done_error", error, d.err);
            chk("done_core_hold", core_hold, d.hold);
            chk("done_busy", busy, 0);
          end
        end
        pv = axi.s_axi_awvalid && !axi.s_axi_awready;
        pa = axi.s_axi_awaddr;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_awvalid", axi.s_axi_awvalid, 0);
    chk("rst_wvalid", axi.s_axi_wvalid, 0);
    chk("rst_wlast", axi.s_axi_wlast, 0);
    chk("rst_bready", axi.s_axi_bready, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_awaddr", axi.s_axi_awaddr, 0);
    chk("rst_awlen", axi.s_axi_awlen, 0);
    chk("rst_core_hold", core_hold, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    exp_aw.delete(); exp_w.delete(); exp_done.delete(); src_q.delete(); mem.delete();
    hold_m = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
  endtask

  // Reference model: split the load into page-safe bursts, queue expectations, pulse start.
  task automatic load_start(input logic [31:0] base, input int cnt, input bit st, input int eb);
    logic [31:0] a, wd;
    int rem, bi, b, room;
    cur_keys.delete(); cur_vals.delete(); cur_ok = 1;
    stall = st; err_burst = eb; b_idx = 0;
    a = base & 32'hFFFF_FFFC; rem = cnt; bi = 0;
    while (rem > 0 && cur_ok) begin
      room = (4096 - int'(a & 32'hFFF)) / 4;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      exp_aw.push_back('{addr: a, len: 8'(b - 1)});
      for (int j = 0; j < b; j++) begin
        wd = $urandom;
        exp_w.push_back('{data: wd, last: (j == b - 1)});
        src_q.push_back(wd);
        cur_keys.push_back(int'(a >> 2) + j);
        cur_vals.push_back(wd);
      end
      a += 32'(4 * b); rem -= b;
      if (bi == eb) cur_ok = 0;
      bi++;
    end
    cur_left = rem;
    for (int j = 0; j < rem; j++) src_q.push_back($urandom);
    exp_done.push_back('{err: !cur_ok, hold: cur_ok ? 1'b0 : hold_m});
    if (cur_ok) hold_m = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = 16'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    if (cnt == 0) begin
      chk("zero_done", done, 1);
      chk("zero_no_aw", axi.s_axi_awvalid, 0);
    end else begin
      chk("start_awvalid", axi.s_axi_awvalid, 1);
      chk("start_busy", busy, 1);
      chk("start_err_clr", error, 0);
    end
  endtask

  task automatic load_finish(input int cnt);
    bit seen;
    seen = (cnt == 0);
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("err_sticky", error, !cur_ok);
    chk("busy_clear", busy, 0);
    for (int i = 0; i < cur_keys.size(); i++)
      chk("mem_word", mem.exists(cur_keys[i]) ? {32'h0, mem[cur_keys[i]]} : 64'hFFFF_FFFF_FFFF_FFFF,
          cur_vals[i]);
    chk("src_left", src_q.size(), cur_left);
    chk("aw_drained", exp_aw.size(), 0);
    chk("w_drained", exp_w.size(), 0);
    chk("done_drained", exp_done.size(), 0);
    src_q.delete();
  endtask

  task automatic run_load(input logic [31:0] base, input int cnt, input bit st, input int eb);
    load_start(base, cnt, st, eb);
    load_finish(cnt);
  endtask

  initial begin
    int nb;
    do_reset();
    run_load(32'h0, 4, 0, -1);
    run_load(32'h0, 40, 0, -1);
    run_load(32'hFF8, 6, 0, -1);
    do_reset();
    run_load(32'h0, 40, 0, 0);
    run_load(32'h0, 20, 1, -1);
    for (int k = 0; k < 8; k++)
      run_load($urandom & 32'h1FFF, $urandom_range(1, 48), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
    load_start(32'h0, 16, 0, -1);
    nb = 0;
    for (int i = 0; i < 200 && nb < 5; i++) begin
      @(negedge clk);
      if (axi.s_axi_wvalid && axi.s_axi_wready) nb++;
    end
    chk("midw_reached", nb >= 5, 1);
    do_reset();
    run_load(32'h100, 0, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
